// File: rtl/uriscv_dmem_slave.sv
// Data-memory responder for the core's load/store port: one request at a time,
// programmable wait states, byte-lane writes, word reads, error acknowledge.
module uriscv_dmem_slave #(
  parameter int ADDR_W      = 12,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_rd_i,
  input  logic [3:0]  mem_wr_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  output logic        mem_accept_o,
  output logic        mem_ack_o,
  output logic [31:0] mem_data_o,
  output logic        mem_error_o
);

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_next;

  logic              w_req;
  logic              w_take;
  logic              w_err_class;
  logic              w_access_ok;
  logic              w_unused;

  logic [ADDR_W-1:0] r_idx;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wr;
  logic              r_rd;
  logic              r_err;

  logic              r_ack;
  logic              r_resp_err;
  logic              r_resp_rd;
  logic [31:0]       w_rd_word;

  assign w_req        = mem_rd_i | (|mem_wr_i);
  assign mem_accept_o = (r_state == S_IDLE) & ~rst_i;
  assign w_take       = mem_accept_o & w_req;
  // Out of range above the RAM, or a request that is both read and write.
  assign w_err_class  = ((mem_addr_i >> (ADDR_W + 2)) != 32'd0) | (mem_rd_i & (|mem_wr_i));
  assign w_access_ok  = (r_state == S_ACCESS) & ~rst_i & ~r_err;
  assign w_unused     = ^mem_addr_i[1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_take) begin
          if (WAIT_STATES > 0) begin
            w_state_next = S_WAIT;
            w_cnt_next   = WAIT_INIT;
          end else begin
            w_state_next = S_ACCESS;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_next = S_ACCESS;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_ACCESS: w_state_next = S_RESP;
      S_RESP:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd  <= 1'b0;
      r_wr  <= 4'd0;
      r_err <= 1'b0;
    end else if (w_take) begin
      r_idx   <= mem_addr_i[ADDR_W+1:2];
      r_wdata <= mem_data_i;
      r_wr    <= mem_wr_i;
      r_rd    <= mem_rd_i;
      r_err   <= w_err_class;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ack      <= 1'b0;
      r_resp_err <= 1'b0;
      r_resp_rd  <= 1'b0;
    end else if (r_state == S_ACCESS) begin
      r_ack      <= 1'b1;
      r_resp_err <= r_err;
      r_resp_rd  <= r_rd & ~r_err;
    end else begin
      r_ack      <= 1'b0;
      r_resp_err <= 1'b0;
      r_resp_rd  <= 1'b0;
    end
  end

  // One byte-wide RAM per lane so each lane maps onto a byte-enabled block RAM.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_ram [DEPTH];
      logic [7:0] r_q;

      always_ff @(posedge clk_i) begin
        if (w_access_ok && r_wr[gi]) begin
          r_ram[r_idx] <= r_wdata[8*gi +: 8];
        end
        if (w_access_ok && r_rd) begin
          r_q <= r_ram[r_idx];
        end
      end

      assign w_rd_word[8*gi +: 8] = r_q;
    end
  endgenerate

  assign mem_ack_o   = r_ack;
  assign mem_error_o = r_resp_err;
  assign mem_data_o  = r_resp_rd ? w_rd_word : 32'd0;

endmodule
